// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, walks a binary search over the DAC
// code using the synchronized comparator decision, and returns the result with start/done.
module sar_adc_ctrl #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_out,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             valid,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start is a level request sampled only in IDLE while done is low;
    // done is a one-cycle pulse and result/valid stay stable until the next accept.

    localparam int T    = SETTLE_CYCLES + 2;
    localparam int CMAX = (SAMPLE_CYCLES > T) ? SAMPLE_CYCLES : T;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CW-1:0]    SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    WIN_LAST  = CW'(T - 1);
    localparam logic [IW-1:0]    IDX_TOP   = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_MASK  = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [NBITS-1:0] trial_q;
    logic [NBITS-1:0] trial_d;
    logic [NBITS-1:0] bit_mask;
    logic [NBITS-1:0] next_mask;
    logic             sample_q;
    logic [NBITS-1:0] dac_q;
    logic             busy_q;
    logic             done_q;
    logic [NBITS-1:0] result_q;
    logic             valid_q;
    logic             sync1_q;
    logic             cmp_s;

    // cmp_out is asynchronous to clk; nothing else may look at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            cmp_s   <= 1'b0;
        end else begin
            sync1_q <= cmp_out;
            cmp_s   <= sync1_q;
        end
    end

    always_comb begin
        bit_mask          = '0;
        bit_mask[idx_q]   = 1'b1;
        next_mask         = bit_mask >> 1;
        trial_d           = trial_q;
        trial_d[idx_q]    = cmp_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            trial_q  <= '0;
            sample_q <= 1'b0;
            dac_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q still high here means we just left DONE: one dead cycle.
                    if (start && !done_q) begin
                        state_q  <= S_SAMPLE;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b0;
                        trial_q  <= '0;
                        sample_q <= 1'b1;
                        dac_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (cnt_q == SAMP_LAST) begin
                        state_q  <= S_CONVERT;
                        sample_q <= 1'b0;
                        dac_q    <= MSB_MASK;
                        idx_q    <= IDX_TOP;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (cnt_q == WIN_LAST) begin
                        trial_q <= trial_d;
                        cnt_q   <= '0;
                        if (idx_q == '0) begin
                            state_q <= S_DONE;
                            dac_q   <= '0;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                            dac_q <= trial_d | next_mask;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    result_q <= trial_q;
                    valid_q  <= 1'b1;
                    dac_q    <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample      = sample_q;
    assign dac_code    = dac_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign valid       = valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: comparator model on cmp_out, expected results
// queued at start, a negedge monitor pops and checks on every done pulse.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cmp_out;
  logic       sample;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       valid;
  logic [1:0] dbg_state;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [1:0] cmp_mode;  // 0 ideal, 1 tied high, 2 tied low
  logic       glitch;
  logic [7:0] vin_code;

  int  acc_cyc = 0;
  int  last_done_cyc = 0;
  bit  have_done = 0;
  bit  b2b_chk = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;

  sar_adc_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_out(cmp_out),
    .sample(sample), .dac_code(dac_code), .busy(busy), .done(done),
    .result(result), .valid(valid), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Analog input sits just inside the LSB above vin_code, so a trial equal to vin_code keeps its bit.
  always_comb begin
    cmp_out = 1'b0;
    case (cmp_mode)
      2'd0:    cmp_out = (vin_code >= dac_code);
      2'd1:    cmp_out = 1'b1;
      default: cmp_out = 1'b0;
    endcase
    if (glitch) cmp_out = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        acc_cyc = cyc;
        if (b2b_chk && have_done) chk("busy_after_done_gap", cyc - last_done_cyc, 2);
      end
      if (done && !done_prev) begin
        chk("latency", cyc - acc_cyc, 27);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
        end
        chk("valid_at_done", valid, 1);
        chk("busy_at_done", busy, 0);
        last_done_cyc = cyc;
        have_done = 1;
      end
      if (!done && done_prev) chk("done_width", cyc - last_done_cyc, 1);
      busy_prev = busy;
      done_prev = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cmp_mode = 2'd2;
    glitch = 1'b0;
    vin_code = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sample, busy, done, valid, dac_code, result}, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // idle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {sample, busy, done, valid, dac_code, result}, 0);
    end

    // ideal comparator, 0xA5, trial sequence
    cmp_mode = 2'd0;
    vin_code = 8'hA5;
    exp_q.push_back(8'hA5);
    pulse_start();
    chk("accept_busy", busy, 1);
    chk("sample_0", sample, 1);
    @(negedge clk);
    chk("sample_1", sample, 1);
    chk("dac_in_sample", dac_code, 0);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("trial_code", dac_code, seq_a5[b]);
      end
    end
    chk("sample_off", sample, 0);
    drain(60);
    chk("hold_result", result, 8'hA5);
    chk("hold_valid", valid, 1);

    // rails
    cmp_mode = 2'd1;
    exp_q.push_back(8'hFF);
    pulse_start();
    drain(60);
    cmp_mode = 2'd2;
    exp_q.push_back(8'h00);
    pulse_start();
    drain(60);

    // short glitch inside the MSB window, away from the decision point
    exp_q.push_back(8'h00);
    pulse_start();
    repeat (3) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    drain(60);

    // start held high: back-to-back conversions accepted every 29 cycles
    cmp_mode = 2'd0;
    vin_code = 8'h3C;
    repeat (4) exp_q.push_back(8'h3C);
    have_done = 0;
    b2b_chk = 1;
    @(negedge clk);
    start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    drain(200);
    b2b_chk = 0;

    // asynchronous reset in the middle of a conversion
    vin_code = 8'h5A;
    exp_q.push_back(8'h5A);
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {sample, busy, done, valid, dac_code, result}, 0);
    chk("abort_state", dbg_state, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", {done, valid}, 0);
    exp_q.push_back(8'h5A);
    pulse_start();
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
